hilo_acc_unit: RTL and testbench

- Parametrised HI/LO special-register pair for the CPU execute/writeback path; generalises the plain HI/LO store.
- Adds per-half writes and 2-cycle multiply-accumulate (MADD/MSUB) on the {HI,LO} double word, with a valid/ready handshake towards EX and a stall indication.
- Multiplier supplies a ready 2W-bit product; this block only adds or subtracts it.

---
 rtl/hilo_acc_unit.sv | 104 ++++++++++
 tb/tb_hilo_acc_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with per-half writes and a two-cycle MADD/MSUB on {HI,LO}.
// Optional HILO_BYPASS_EN: rd_* forward accepted writes and the committing accumulate result.
module hilo_acc_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [2:0]                op_code,
  input  logic [DATA_WIDTH-1:0]     wr_hi_data,
  input  logic [DATA_WIDTH-1:0]     wr_lo_data,
  input  logic [2*DATA_WIDTH-1:0]   prod,
  output logic [DATA_WIDTH-1:0]     rd_hi_data,
  output logic [DATA_WIDTH-1:0]     rd_lo_data,
  output logic                      busy,
  output logic                      acc_done
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    hi, lo, tmp_lo, hi_res;
  logic [2*W-1:0]  prod_q;
  logic            sub_q, cy;
  logic            accept;

  assign accept = op_valid && op_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (op_code == 3'b100 || op_code == 3'b101)) state_nxt = ACC_LO;
      ACC_LO:  state_nxt = ACC_HI;
      ACC_HI:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state == IDLE) && rst;
    busy     = (state != IDLE);
  end

  // cy holds the low-half carry (MADD) or borrow (MSUB) into the high half
  assign hi_res = sub_q ? hi - prod_q[2*W-1:W] - W'(cy)
                        : hi + prod_q[2*W-1:W] + W'(cy);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi       <= '0;
      lo       <= '0;
      tmp_lo   <= '0;
      prod_q   <= '0;
      sub_q    <= 1'b0;
      cy       <= 1'b0;
      acc_done <= 1'b0;
    end else begin
      acc_done <= (state == ACC_HI);
      case (state)
        IDLE: if (accept) begin
          case (op_code)
            3'b001: hi <= wr_hi_data;
            3'b010: lo <= wr_lo_data;
            3'b011: begin hi <= wr_hi_data; lo <= wr_lo_data; end
            3'b100, 3'b101: begin prod_q <= prod; sub_q <= op_code[0]; end
            default: ;
          endcase
        end
        ACC_LO: {cy, tmp_lo} <= sub_q ? {1'b0, lo} - {1'b0, prod_q[W-1:0]}
                                      : {1'b0, lo} + {1'b0, prod_q[W-1:0]};
        ACC_HI: begin
          hi <= hi_res;
          lo <= tmp_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_hi_data = hi;
    rd_lo_data = lo;
`ifdef HILO_BYPASS_EN
    if (state == ACC_HI) begin
      rd_hi_data = hi_res;
      rd_lo_data = tmp_lo;
    end else if (accept) begin
      if (op_code == 3'b001 || op_code == 3'b011) rd_hi_data = wr_hi_data;
      if (op_code == 3'b010 || op_code == 3'b011) rd_lo_data = wr_lo_data;
    end
`endif
    if (!rst) begin
      rd_hi_data = '0;
      rd_lo_data = '0;
    end
  end
endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed + random bench for hilo_acc_unit against a 64-bit accumulator model.
module tb_hilo_acc_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, op_valid, op_ready, busy, acc_done;
  logic [2:0]     op_code;
  logic [W-1:0]   wr_hi_data, wr_lo_data, rd_hi_data, rd_lo_data;
  logic [2*W-1:0] prod;

  int compared = 0, mismatched = 0;

  // model: whole {HI,LO} value, pending result and cycles left until commit
  logic [63:0] m_acc = '0, m_pval = '0;
  int          m_pend = 0;
  logic        m_done = 1'b0;

  always #5 clk = ~clk;

  hilo_acc_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .wr_hi_data(wr_hi_data), .wr_lo_data(wr_lo_data), .prod(prod),
    .rd_hi_data(rd_hi_data), .rd_lo_data(rd_lo_data), .busy(busy), .acc_done(acc_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd();
    logic [63:0] v;
    if (!rst) return 64'h0;
    v = m_acc;
`ifdef HILO_BYPASS_EN
    if (m_pend == 1) v = m_pval;
    else if (m_pend == 0 && op_valid) begin
      if (op_code == 3'd1 || op_code == 3'd3) v[63:32] = wr_hi_data;
      if (op_code == 3'd2 || op_code == 3'd3) v[31:0]  = wr_lo_data;
    end
`endif
    return v;
  endfunction

  task automatic check_all();
    logic [63:0] e;
    e = exp_rd();
    chk("rd_hi", {32'h0, rd_hi_data}, {32'h0, e[63:32]});
    chk("rd_lo", {32'h0, rd_lo_data}, {32'h0, e[31:0]});
    chk("op_ready", {63'h0, op_ready}, {63'h0, rst && m_pend == 0});
    chk("busy", {63'h0, busy}, {63'h0, m_pend != 0});
    chk("acc_done", {63'h0, acc_done}, {63'h0, m_done});
  endtask

  task automatic tick();
    logic [63:0] acc, pval;
    int          pend;
    logic        done;
    acc = m_acc; pval = m_pval; pend = m_pend; done = 1'b0;
    if (!rst) begin
      acc = '0; pend = 0;
    end else if (pend != 0) begin
      pend--;
      if (pend == 0) begin acc = pval; done = 1'b1; end
    end else if (op_valid) begin
      case (op_code)
        3'd1: acc[63:32] = wr_hi_data;
        3'd2: acc[31:0]  = wr_lo_data;
        3'd3: acc = {wr_hi_data, wr_lo_data};
        3'd4: begin pval = acc + prod; pend = 2; end
        3'd5: begin pval = acc - prod; pend = 2; end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    m_acc = acc; m_pval = pval; m_pend = pend; m_done = done;
    check_all();
  endtask

  task automatic drv(input logic v, input logic [2:0] c, input logic [W-1:0] h,
                     input logic [W-1:0] l, input logic [2*W-1:0] p);
    op_valid = v; op_code = c; wr_hi_data = h; wr_lo_data = l; prod = p;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 3'd0, '0, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit was_ready;
    rst = 1'b0;
    drv(1'b0, 3'd0, '0, '0, '0);
    tick(); tick();
    rst = 1'b1; #1 check_all();

    // reset clears a preloaded value
    drv(1'b1, 3'd3, 32'h12345678, 32'h12345678, '0); tick();
    drv(1'b0, 3'd0, '0, '0, '0);
    rst = 1'b0; #1 check_all();
    tick();
    rst = 1'b1; #1 check_all();

    drv(1'b1, 3'd1, 32'hDEADBEEF, 32'h0, '0); tick();
    drv(1'b1, 3'd2, 32'h0, 32'h00000001, '0); tick();
    idle(1);
    chk("wr_halves", {rd_hi_data, rd_lo_data}, 64'hDEADBEEF_00000001);
    drv(1'b1, 3'd3, 32'hA, 32'hB, '0); tick();
    idle(1);
    chk("wr_both", {rd_hi_data, rd_lo_data}, 64'h0000000A_0000000B);

    drv(1'b1, 3'd3, 32'h0, 32'hFFFFFFFF, '0); tick();
    drv(1'b1, 3'd4, '0, '0, 64'h1); tick();
    idle(4);
    chk("madd_carry", {rd_hi_data, rd_lo_data}, 64'h00000001_00000000);

    drv(1'b1, 3'd3, 32'h1, 32'h0, '0); tick();
    drv(1'b1, 3'd5, '0, '0, 64'h1); tick();
    idle(3);
    chk("msub_borrow", {rd_hi_data, rd_lo_data}, 64'h00000000_FFFFFFFF);

    drv(1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, '0); tick();
    drv(1'b1, 3'd4, '0, '0, 64'h1); tick();
    idle(3);
    chk("madd_wrap", {rd_hi_data, rd_lo_data}, 64'h0);

    // WR_LO held while busy must land after the accumulate
    drv(1'b1, 3'd4, '0, '0, {$urandom, $urandom}); tick();
    drv(1'b1, 3'd2, '0, 32'h55, '0);
    for (int i = 0; i < 6; i++) begin
      was_ready = (m_pend == 0);
      tick();
      if (was_ready) break;
    end
    idle(1);
    chk("bp_lo", {32'h0, rd_lo_data}, 64'h55);

    // reset in ACC_LO aborts the accumulate
    drv(1'b1, 3'd3, 32'h3, 32'h4, '0); tick();
    drv(1'b1, 3'd4, '0, '0, 64'h5); tick();
    drv(1'b0, 3'd0, '0, '0, '0);
    rst = 1'b0; tick();
    rst = 1'b1; idle(3);
    chk("abort", {rd_hi_data, rd_lo_data}, 64'h0);

`ifdef HILO_BYPASS_EN
    drv(1'b1, 3'd1, 32'h7, '0, '0); #1;
    chk("byp_hi", {32'h0, rd_hi_data}, 64'h7);
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 50) != 0;
      drv($urandom % 2 == 0, 3'($urandom % 8), $urandom, $urandom, {$urandom, $urandom});
      tick();
    end
    rst = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
